// File: rtl/hqm_aw_rf_pg_32x11_ctl.sv
// -----------------------------------------------------------------------------
// hqm_aw_rf_pg_32x11_ctl
//
// Power-gate / reset / init sequencer for one 32x11 power-gated register file.
// It also gates functional traffic into the RF. It runs on the RF clock.
//
// Power-up order:
//   pwr_enable_b low -> ack -> ISO_WAIT cycles -> isolation off
//   -> RST_WAIT cycles -> ip_reset_b high -> zero-fill all entries -> ready.
// Power-down order:
//   isolation on + ip_reset_b low (one cycle) -> pwr_enable_b high
//   -> wait for ack high -> off.
// If an ack does not arrive within ACK_TIMEOUT cycles, the block parks in ERR
// with the RF isolated and unpowered.
//
// Ports
//   clk, rst_n          RF clock; synchronous active-low reset
//   pwr_up_req          level, RF must be powered and ready (wins over dn)
//   pwr_dn_req          level, power down when idle
//   we_in/waddr_in/wdata_in, re_in/raddr_in   functional requests
//   acc_rdy             request accepted this cycle (only while ready)
//   rvalid              read data valid, one cycle after rf_re
//   ready, busy         sequencer status
//   err_timeout         power-ack timeout (held until ERR is exited or reset)
//   rf_we/rf_waddr/rf_wdata, rf_re/rf_raddr   RF array ports
//   rf_isol_en, rf_pwr_enable_b, rf_ip_reset_b RF power-control pins
//   rf_pwr_ack_b        RF power acknowledge (0 = powered)
//
// Handshake: a request is taken when acc_rdy is high in a cycle (ready and
// we_in or re_in). It is issued to the RF on the next cycle. A request seen
// while acc_rdy is low is dropped, and the requester must hold it and retry.
// -----------------------------------------------------------------------------
module hqm_aw_rf_pg_32x11_ctl #(
   parameter int ISO_WAIT    = 4,
   parameter int RST_WAIT    = 8,
   parameter int ACK_TIMEOUT = 256,
   parameter int DEPTH       = 32,
   parameter int DWIDTH      = 11
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pwr_up_req,
   input  logic                     pwr_dn_req,
   input  logic                     we_in,
   input  logic [$clog2(DEPTH)-1:0] waddr_in,
   input  logic [DWIDTH-1:0]        wdata_in,
   input  logic                     re_in,
   input  logic [$clog2(DEPTH)-1:0] raddr_in,
   output logic                     acc_rdy,
   output logic                     rvalid,
   output logic                     ready,
   output logic                     busy,
   output logic                     err_timeout,
   output logic                     rf_we,
   output logic [$clog2(DEPTH)-1:0] rf_waddr,
   output logic [DWIDTH-1:0]        rf_wdata,
   output logic                     rf_re,
   output logic [$clog2(DEPTH)-1:0] rf_raddr,
   output logic                     rf_isol_en,
   output logic                     rf_pwr_enable_b,
   input  logic                     rf_pwr_ack_b,
   output logic                     rf_ip_reset_b
);

   localparam int AW   = $clog2(DEPTH);
   localparam int M1   = (ACK_TIMEOUT > DEPTH) ? ACK_TIMEOUT : DEPTH;
   localparam int M2   = (ISO_WAIT > RST_WAIT) ? ISO_WAIT : RST_WAIT;
   localparam int CMAX = (M1 > M2) ? M1 : M2;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [3:0] {
      S_OFF, S_PWR_ON, S_ISO_WAIT, S_RST_HOLD, S_INIT,
      S_READY, S_PWR_DN, S_PWR_OFF, S_ERR
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            init_act;

   logic            fwd_we, fwd_re;
   logic [AW-1:0]   fwd_waddr, fwd_raddr;
   logic [DWIDTH-1:0] fwd_wdata;

   // State register. The counter clears on every state change and saturates
   // at all-ones, so it never wraps while the FSM sits in a state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_OFF;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) cnt <= '0;
         else if (cnt != '1)     cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt       = state;
      rf_isol_en      = 1'b1;
      rf_pwr_enable_b = 1'b1;
      rf_ip_reset_b   = 1'b0;
      ready           = 1'b0;
      busy            = 1'b1;
      err_timeout     = 1'b0;
      init_act        = 1'b0;
      case (state)
         S_OFF: begin
            busy = 1'b0;
            if (pwr_up_req) state_nxt = S_PWR_ON;
         end
         S_PWR_ON: begin
            rf_pwr_enable_b = 1'b0;
            if (!rf_pwr_ack_b)                        state_nxt = S_ISO_WAIT;
            else if (cnt == CW'(ACK_TIMEOUT - 1))     state_nxt = S_ERR;
         end
         S_ISO_WAIT: begin
            rf_pwr_enable_b = 1'b0;
            if (cnt == CW'(ISO_WAIT - 1)) state_nxt = S_RST_HOLD;
         end
         S_RST_HOLD: begin
            rf_pwr_enable_b = 1'b0;
            rf_isol_en      = 1'b0;
            if (cnt == CW'(RST_WAIT - 1)) state_nxt = S_INIT;
         end
         S_INIT: begin
            rf_pwr_enable_b = 1'b0;
            rf_isol_en      = 1'b0;
            rf_ip_reset_b   = 1'b1;
            init_act        = 1'b1;
            if (cnt == CW'(DEPTH - 1)) state_nxt = S_READY;
         end
         S_READY: begin
            rf_pwr_enable_b = 1'b0;
            rf_isol_en      = 1'b0;
            rf_ip_reset_b   = 1'b1;
            ready           = 1'b1;
            busy            = 1'b0;
            if (pwr_dn_req && !pwr_up_req) state_nxt = S_PWR_DN;
         end
         S_PWR_DN: begin
            // Isolation and ip reset assert together while power stays on.
            rf_pwr_enable_b = 1'b0;
            state_nxt       = S_PWR_OFF;
         end
         S_PWR_OFF: begin
            if (rf_pwr_ack_b)                         state_nxt = S_OFF;
            else if (cnt == CW'(ACK_TIMEOUT - 1))     state_nxt = S_ERR;
         end
         S_ERR: begin
            busy        = 1'b0;
            err_timeout = 1'b1;
            if (!pwr_up_req && pwr_dn_req) state_nxt = S_OFF;
         end
         default: state_nxt = S_OFF;
      endcase
   end

   assign acc_rdy = ready & (we_in | re_in);

   // Functional forwarding. A request accepted in READY reaches the RF one
   // cycle later, even if the FSM has moved to PWR_DN by then. This lets a
   // read accepted in the last READY cycle still produce rvalid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_we    <= 1'b0;
         fwd_re    <= 1'b0;
         fwd_waddr <= '0;
         fwd_raddr <= '0;
         fwd_wdata <= '0;
         rvalid    <= 1'b0;
      end else begin
         fwd_we <= ready & we_in;
         fwd_re <= ready & re_in;
         if (ready && we_in) begin
            fwd_waddr <= waddr_in;
            fwd_wdata <= wdata_in;
         end
         if (ready && re_in) fwd_raddr <= raddr_in;
         rvalid <= fwd_re;
      end
   end

   // During INIT the low counter bits are the fill address, 0..DEPTH-1.
   assign rf_we    = init_act | fwd_we;
   assign rf_waddr = init_act ? cnt[AW-1:0] : fwd_waddr;
   assign rf_wdata = init_act ? '0 : fwd_wdata;
   assign rf_re    = fwd_re;
   assign rf_raddr = fwd_raddr;

endmodule

// File: tb/tb_hqm_aw_rf_pg_32x11_ctl.sv
// -----------------------------------------------------------------------------
// tb_hqm_aw_rf_pg_32x11_ctl
//
// Directed bench for the RF power-gate controller.
// Each expected RF write or read is queued at the moment it is requested.
// A monitor pops the queue whenever rf_we or rf_re is seen.
// The main sequence checks power-pin ordering and cycle counts.
// -----------------------------------------------------------------------------
module tb_hqm_aw_rf_pg_32x11_ctl;

   localparam int ISO_W = 4;
   localparam int RST_W = 8;
   localparam int ACK_T = 256;
   localparam int DEP   = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pwr_up_req, pwr_dn_req;
   logic        we_in, re_in;
   logic [4:0]  waddr_in, raddr_in;
   logic [10:0] wdata_in;
   logic        acc_rdy, rvalid, ready, busy, err_timeout;
   logic        rf_we, rf_re;
   logic [4:0]  rf_waddr, rf_raddr;
   logic [10:0] rf_wdata;
   logic        rf_isol_en, rf_pwr_enable_b, rf_pwr_ack_b, rf_ip_reset_b;

   int vectors = 0;
   int miscompares = 0;
   logic [15:0] exp_wq[$];
   logic [4:0]  exp_rq[$];

   hqm_aw_rf_pg_32x11_ctl #(
      .ISO_WAIT(ISO_W), .RST_WAIT(RST_W), .ACK_TIMEOUT(ACK_T), .DEPTH(DEP), .DWIDTH(11)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pwr_up_req(pwr_up_req), .pwr_dn_req(pwr_dn_req),
      .we_in(we_in), .waddr_in(waddr_in), .wdata_in(wdata_in),
      .re_in(re_in), .raddr_in(raddr_in),
      .acc_rdy(acc_rdy), .rvalid(rvalid), .ready(ready), .busy(busy),
      .err_timeout(err_timeout),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rf_re(rf_re), .rf_raddr(rf_raddr),
      .rf_isol_en(rf_isol_en), .rf_pwr_enable_b(rf_pwr_enable_b),
      .rf_pwr_ack_b(rf_pwr_ack_b), .rf_ip_reset_b(rf_ip_reset_b)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [15:0] ew;
      logic [4:0]  er;
      if (rf_we === 1'b1) begin
         if (exp_wq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rf_we: got addr %0h data %0h expected no write", rf_waddr, rf_wdata);
         end else begin
            ew = exp_wq.pop_front();
            check("rf_write", {16'h0, rf_waddr, rf_wdata}, {16'h0, ew});
         end
      end
      if (rf_re === 1'b1) begin
         if (exp_rq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rf_re: got addr %0h expected no read", rf_raddr);
         end else begin
            er = exp_rq.pop_front();
            check("rf_read", {27'h0, rf_raddr}, {27'h0, er});
         end
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_isol"},   rf_isol_en, 1);
      check({tag, "_pwr_b"},  rf_pwr_enable_b, 1);
      check({tag, "_ipr_b"},  rf_ip_reset_b, 0);
      check({tag, "_we"},     rf_we, 0);
      check({tag, "_re"},     rf_re, 0);
      check({tag, "_rvalid"}, rvalid, 0);
      check({tag, "_ready"},  ready, 0);
      check({tag, "_busy"},   busy, 0);
      check({tag, "_err"},    err_timeout, 0);
   endtask

   // directed sequence
   initial begin
      int n;
      int k;
      rst_n = 1'b0; pwr_up_req = 1'b0; pwr_dn_req = 1'b0;
      we_in = 1'b0; re_in = 1'b0; waddr_in = '0; raddr_in = '0; wdata_in = '0;
      rf_pwr_ack_b = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      check("reset_acc", acc_rdy, 0);

      // power-up, ack three cycles after pwr_enable_b falls
      rst_n = 1'b1;
      for (int i = 0; i < DEP; i++) exp_wq.push_back({5'(i), 11'h000});
      pwr_up_req = 1'b1;
      @(negedge clk);
      check("pwron_pwr_b", rf_pwr_enable_b, 0);
      check("pwron_busy", busy, 1);
      check("pwron_isol", rf_isol_en, 1);
      repeat (2) @(negedge clk);
      check("pre_ack_pwr_b", rf_pwr_enable_b, 0);
      rf_pwr_ack_b = 1'b0;
      // The ack is sampled on the edge that enters ISO_WAIT, which then lasts ISO_W cycles.
      n = 0;
      do begin @(negedge clk); n++; end while (rf_isol_en !== 1'b0 && n < 50);
      check("iso_wait_cycles", n, ISO_W + 1);
      check("iso_ipr_still_low", rf_ip_reset_b, 0);
      n = 0;
      do begin @(negedge clk); n++; end while (rf_ip_reset_b !== 1'b1 && n < 50);
      check("rst_hold_cycles", n, RST_W);
      check("init_first_we", rf_we, 1);
      n = 0;
      do begin @(negedge clk); n++; end while (ready !== 1'b1 && n < 100);
      check("init_cycles", n, DEP);
      check("init_all_written", exp_wq.size(), 0);
      check("ready_busy", busy, 0);

      // functional write then read of address 7
      check("acc_idle", acc_rdy, 0);
      we_in = 1'b1; waddr_in = 5'd7; wdata_in = 11'h5A5;
      exp_wq.push_back({5'd7, 11'h5A5});
      #1 check("acc_wr", acc_rdy, 1);
      @(negedge clk);
      check("wr_latency", rf_we, 1);
      we_in = 1'b0; re_in = 1'b1; raddr_in = 5'd7;
      exp_rq.push_back(5'd7);
      #1 check("acc_rd", acc_rdy, 1);
      @(negedge clk);
      check("rd_latency", rf_re, 1);
      check("rvalid_not_yet", rvalid, 0);
      re_in = 1'b0;
      @(negedge clk);
      check("rvalid_pulse", rvalid, 1);
      check("rd_single", rf_re, 0);

      // simultaneous write and read
      we_in = 1'b1; waddr_in = 5'd3; wdata_in = 11'h123;
      re_in = 1'b1; raddr_in = 5'd9;
      exp_wq.push_back({5'd3, 11'h123});
      exp_rq.push_back(5'd9);
      #1 check("acc_both", acc_rdy, 1);
      @(negedge clk);
      check("both_we", rf_we, 1);
      check("both_re", rf_re, 1);
      we_in = 1'b0; re_in = 1'b0;
      @(negedge clk);
      check("both_rvalid", rvalid, 1);

      // read accepted in the cycle pwr_dn_req rises, then drain and power-off
      re_in = 1'b1; raddr_in = 5'd20;
      exp_rq.push_back(5'd20);
      pwr_up_req = 1'b0; pwr_dn_req = 1'b1;
      #1 check("acc_last_ready", acc_rdy, 1);
      @(negedge clk);
      check("drain_re", rf_re, 1);
      check("pwrdn_isol", rf_isol_en, 1);
      check("pwrdn_ipr_b", rf_ip_reset_b, 0);
      check("pwrdn_pwr_b_still_on", rf_pwr_enable_b, 0);
      check("pwrdn_ready", ready, 0);
      check("pwrdn_busy", busy, 1);
      raddr_in = 5'd21;
      #1 check("acc_pwrdn", acc_rdy, 0);
      @(negedge clk);
      check("drain_rvalid", rvalid, 1);
      check("no_re_after_dn", rf_re, 0);
      check("pwroff_pwr_b", rf_pwr_enable_b, 1);
      re_in = 1'b0;
      rf_pwr_ack_b = 1'b1;
      @(negedge clk);
      check("off_busy", busy, 0);
      check("off_isol", rf_isol_en, 1);
      pwr_dn_req = 1'b0;

      // ack never arrives -> timeout
      pwr_up_req = 1'b1;
      n = 0; k = 0;
      do begin
         @(negedge clk);
         k++;
         if (rf_pwr_enable_b === 1'b0) n++;
      end while (err_timeout !== 1'b1 && k < 400);
      check("timeout_seen", err_timeout, 1);
      check("timeout_pwron_cycles", n, ACK_T);
      check("err_isol", rf_isol_en, 1);
      check("err_pwr_b", rf_pwr_enable_b, 1);
      check("err_ipr_b", rf_ip_reset_b, 0);
      check("err_busy", busy, 0);
      pwr_dn_req = 1'b1;
      @(negedge clk);
      check("err_held_up_priority", err_timeout, 1);
      pwr_up_req = 1'b0;
      @(negedge clk);
      check("err_cleared", err_timeout, 0);
      check("err_exit_busy", busy, 0);
      pwr_dn_req = 1'b0;
      @(negedge clk);
      check("off_stays", rf_pwr_enable_b, 1);

      // reset during init at address 15, then full re-init
      for (int i = 0; i < 16; i++) exp_wq.push_back({5'(i), 11'h000});
      pwr_up_req = 1'b1;
      @(negedge clk);
      rf_pwr_ack_b = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!(rf_we === 1'b1 && rf_waddr == 5'd15) && n < 100);
      check("init_addr15_seen", rf_waddr, 15);
      rst_n = 1'b0; pwr_up_req = 1'b0; rf_pwr_ack_b = 1'b1;
      @(negedge clk);
      check_reset_values("midrst");
      check("midrst_waddr", rf_waddr, 0);
      rst_n = 1'b1;
      for (int i = 0; i < DEP; i++) exp_wq.push_back({5'(i), 11'h000});
      pwr_up_req = 1'b1;
      @(negedge clk);
      check("reinit_pwr_b", rf_pwr_enable_b, 0);
      rf_pwr_ack_b = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (ready !== 1'b1 && n < 100);
      check("reinit_ready", ready, 1);
      check("reinit_all_written", exp_wq.size(), 0);
      pwr_up_req = 1'b0;
      @(negedge clk);
      check("reads_all_seen", exp_rq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule
